// File: rtl/spi_flash_arbiter_if.sv
// Signal bundle shared by the two flash requesters, the arbiter and the flash pins.
// The master side is the requesters plus the flash; the slave side is the arbiter.
interface spi_flash_arbiter_if;
  logic       req0, gnt0, csel0, sclk0, mosi0, miso0;
  logic       req1, gnt1, csel1, sclk1, mosi1, miso1;
  logic [1:0] abort;
  logic       busy;
  logic       spi_csel, spi_clk, spi_mosi, spi_miso;

  modport master (
    output req0, csel0, sclk0, mosi0,
    output req1, csel1, sclk1, mosi1,
    output spi_miso,
    input  gnt0, miso0, gnt1, miso1,
    input  abort, busy, spi_csel, spi_clk, spi_mosi
  );

  modport slave (
    input  req0, csel0, sclk0, mosi0,
    input  req1, csel1, sclk1, mosi1,
    input  spi_miso,
    output gnt0, miso0, gnt1, miso1,
    output abort, busy, spi_csel, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Two-port SPI flash arbiter: DFU engine (port 0) and boot header reader (port 1)
// share one flash, with a chip-select-high gap between owners and an optional hold limit.
module spi_flash_arbiter #(
  parameter int CS_GAP     = 4,
  parameter int HOLD_LIMIT = 0
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  spi_flash_arbiter_if.slave bus
);

  // CS_GAP must be at least 1; the gap counter only has to reach CS_GAP-1.
  localparam int                 GAP_W     = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [23:0]        HOLD_LAST = 24'(HOLD_LIMIT - 1);
  localparam bit                 HOLD_EN   = (HOLD_LIMIT != 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t           state, state_nxt;
  logic             last_owner, last_owner_nxt;
  logic             lockout0, lockout0_nxt;
  logic             lockout1, lockout1_nxt;
  logic [23:0]      hold_cnt, hold_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [1:0]       abort_q, abort_nxt;
  logic             elig0, elig1, hold_hit;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      lockout0   <= 1'b0;
      lockout1   <= 1'b0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      abort_q    <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      lockout0   <= lockout0_nxt;
      lockout1   <= lockout1_nxt;
      hold_cnt   <= hold_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      abort_q    <= abort_nxt;
    end
  end

  always_comb begin
    elig0          = bus.req0 && !lockout0;
    elig1          = bus.req1 && !lockout1;
    hold_hit       = HOLD_EN && (hold_cnt == HOLD_LAST);
    state_nxt      = state;
    last_owner_nxt = last_owner;
    // A lockout survives only while its requester keeps req asserted.
    lockout0_nxt   = lockout0 && bus.req0;
    lockout1_nxt   = lockout1 && bus.req1;
    hold_cnt_nxt   = hold_cnt + 24'd1;
    gap_cnt_nxt    = '0;
    abort_nxt      = '0;

    bus.gnt0     = (state == OWN0);
    bus.gnt1     = (state == OWN1);
    bus.busy     = (state != IDLE);
    bus.abort    = abort_q;
    bus.spi_csel = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.miso0    = 1'b0;
    bus.miso1    = 1'b0;

    case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (elig0 && (!elig1 || last_owner)) begin
          state_nxt      = OWN0;
          last_owner_nxt = 1'b0;
        end else if (elig1) begin
          state_nxt      = OWN1;
          last_owner_nxt = 1'b1;
        end
      end
      OWN0: begin
        bus.spi_csel = bus.csel0;
        bus.spi_clk  = bus.sclk0;
        bus.spi_mosi = bus.mosi0;
        bus.miso0    = bus.spi_miso;
        // A voluntary release on the limit cycle wins over the forced one.
        if (!bus.req0) begin
          state_nxt = GAP;
        end else if (hold_hit) begin
          state_nxt    = GAP;
          abort_nxt[0] = 1'b1;
          lockout0_nxt = 1'b1;
        end
      end
      OWN1: begin
        bus.spi_csel = bus.csel1;
        bus.spi_clk  = bus.sclk1;
        bus.spi_mosi = bus.mosi1;
        bus.miso1    = bus.spi_miso;
        if (!bus.req1) begin
          state_nxt = GAP;
        end else if (hold_hit) begin
          state_nxt    = GAP;
          abort_nxt[1] = 1'b1;
          lockout1_nxt = 1'b1;
        end
      end
      GAP: begin
        hold_cnt_nxt = '0;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: directed scenarios and random traffic against a
// cycle-level reference model, with a scoreboard monitor checking every output.
module tb_spi_flash_arbiter;
  localparam int CS_GAP     = 4;
  localparam int HOLD_LIMIT = 100;
  localparam int MAXC       = 8192;
  localparam logic [9:0] IDLE_OUT = 10'b00000_10000;

  bit   clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_arbiter_if bus ();

  spi_flash_arbiter #(.CS_GAP(CS_GAP), .HOLD_LIMIT(HOLD_LIMIT)) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  // Output vector: {gnt0, gnt1, busy, abort[1:0], spi_csel, spi_clk, spi_mosi, miso0, miso1}
  logic [9:0] exp_q[$];
  int         cyc_q[$];
  logic [9:0] obs[MAXC];
  logic [3:0] drv[MAXC];
  int         g_cyc[$];
  int         g_port[$];
  int         cyc = 0;
  bit         stim_done = 1'b0;
  bit         fix_cs0 = 1'b0, fix_cs1 = 1'b0;
  int         c_req, c_n, c_d, c_e, c_f, c_r;
  int         n_chk = 0, n_fail = 0;

  // Reference model: who owns the bus, how long, gap remaining, lockouts.
  int       m_owner;
  int       m_gap;
  int       m_held;
  bit       m_lock0, m_lock1, m_last;
  bit [1:0] m_abort;

  function automatic void model_reset();
    m_owner = -1; m_gap = 0; m_held = 0;
    m_lock0 = 1'b0; m_lock1 = 1'b0; m_last = 1'b1; m_abort = 2'b00;
  endfunction

  function automatic void model_advance(input bit rst_v, input bit r0, input bit r1);
    bit e0, e1, rq;
    bit [1:0] ab;
    e0 = r0 && !m_lock0;
    e1 = r1 && !m_lock1;
    ab = 2'b00;
    if (rst_v) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      rq = (m_owner == 0) ? r0 : r1;
      m_held++;
      if (!rq) begin
        m_owner = -1; m_gap = CS_GAP;
      end else if (HOLD_LIMIT != 0 && m_held == HOLD_LIMIT) begin
        if (m_owner == 0) begin ab[0] = 1'b1; m_lock0 = 1'b1; end
        else begin ab[1] = 1'b1; m_lock1 = 1'b1; end
        m_owner = -1; m_gap = CS_GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (e0 || e1) begin
      if (e0 && e1) m_owner = m_last ? 0 : 1;
      else          m_owner = e0 ? 0 : 1;
      m_last = (m_owner == 1);
      m_held = 0;
    end
    if (!r0) m_lock0 = 1'b0;
    if (!r1) m_lock1 = 1'b0;
    m_abort = ab;
  endfunction

  task automatic step(input bit rst_v, input bit r0, input bit r1);
    bit c0, k0, m0, c1, k1, m1, mi;
    logic [9:0] e;
    @(posedge clk); #1;
    c0 = fix_cs0 ? 1'b0 : 1'($urandom_range(0, 1));
    k0 = 1'($urandom_range(0, 1));
    m0 = 1'($urandom_range(0, 1));
    c1 = fix_cs1 ? 1'b0 : 1'($urandom_range(0, 1));
    k1 = 1'($urandom_range(0, 1));
    m1 = 1'($urandom_range(0, 1));
    mi = 1'($urandom_range(0, 1));
    reset = rst_v;
    bus.req0 = r0; bus.csel0 = c0; bus.sclk0 = k0; bus.mosi0 = m0;
    bus.req1 = r1; bus.csel1 = c1; bus.sclk1 = k1; bus.mosi1 = m1;
    bus.spi_miso = mi;
    cyc++;
    e = IDLE_OUT;
    e[9]   = (m_owner == 0);
    e[8]   = (m_owner == 1);
    e[7]   = (m_owner >= 0) || (m_gap > 0);
    e[6:5] = m_abort;
    if (m_owner == 0) begin
      e[4] = c0; e[3] = k0; e[2] = m0; e[1] = mi;
    end else if (m_owner == 1) begin
      e[4] = c1; e[3] = k1; e[2] = m1; e[0] = mi;
    end
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    drv[cyc] = {c0, k0, m0, mi};
    model_advance(rst_v, r0, r1);
  endtask

  initial begin : driver
    bit r0, r1;
    int h0, h1;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.csel0 = 1'b1; bus.sclk0 = 1'b0; bus.mosi0 = 1'b0;
    bus.req1 = 1'b0; bus.csel1 = 1'b1; bus.sclk1 = 1'b0; bus.mosi1 = 1'b0;
    bus.spi_miso = 1'b0;
    model_reset();

    repeat (3) step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    // Single requester, then a pending port 1 and release with csel0 low.
    step(0, 1, 0); c_req = cyc;
    repeat (7) step(0, 1, 0);
    repeat (8) step(0, 1, 1);
    fix_cs0 = 1'b1;
    step(0, 0, 1); c_n = cyc;
    fix_cs0 = 1'b0;
    repeat (12) step(0, 0, 1);
    repeat (8) step(0, 0, 0);

    // Round-robin: both held, each owner drops for one cycle after 20 grant cycles.
    step(1, 0, 0);
    c_d = cyc + 1;
    r0 = 1'b1; r1 = 1'b1; h0 = 0; h1 = 0;
    repeat (160) begin
      step(0, r0, r1);
      if (bus.gnt0 && r0) h0++;
      if (bus.gnt1 && r1) h1++;
      r0 = 1'b1; r1 = 1'b1;
      if (h0 == 20) begin r0 = 1'b0; h0 = 0; end
      if (h1 == 20) begin r1 = 1'b0; h1 = 0; end
    end
    repeat (8) step(0, 0, 0);

    // Hold limit on port 1, lockout, then lockout cleared by a one-cycle drop.
    step(0, 0, 1); c_e = cyc;
    repeat (100) step(0, 0, 1);
    repeat (40) step(0, 1, 1);
    step(0, 1, 0);
    repeat (9) step(0, 1, 1);
    step(0, 0, 1);
    repeat (14) step(0, 0, 1);
    repeat (8) step(0, 0, 0);

    // Release on the same cycle the limit would hit.
    step(0, 1, 0); c_f = cyc;
    repeat (99) step(0, 1, 0);
    step(0, 0, 0);
    repeat (10) step(0, 1, 0);
    repeat (8) step(0, 0, 0);

    // Reset in the middle of a port 1 transfer.
    step(0, 0, 1);
    fix_cs1 = 1'b1;
    repeat (4) step(0, 0, 1);
    step(1, 1, 1); c_r = cyc;
    fix_cs1 = 1'b0;
    repeat (6) step(0, 1, 1);
    repeat (8) step(0, 0, 0);

    r0 = 1'b0; r1 = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 47) == 0) r0 = !r0;
      if ($urandom_range(0, 47) == 0) r1 = !r1;
      step(($urandom_range(0, 999) == 0), r0, r1);
    end
    repeat (2) step(0, 0, 0);
    stim_done = 1'b1;
  end

  task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int cnt(input int lo, input int hi, input int b);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (obs[c][b] === 1'b1) n++;
    return n;
  endfunction

  initial begin : monitor
    logic [9:0] e, act;
    int c, k;
    bit pg0, pg1;
    int rr_c[4];
    int rr_p[4];
    pg0 = 1'b0; pg1 = 1'b0;
    while (!(stim_done && exp_q.size() == 0)) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        act = {bus.gnt0, bus.gnt1, bus.busy, bus.abort, bus.spi_csel,
               bus.spi_clk, bus.spi_mosi, bus.miso0, bus.miso1};
        obs[c] = act;
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %b, expected %b", c, act, e);
        end
        if (act[9] === 1'b1 && !pg0) begin g_cyc.push_back(c); g_port.push_back(0); end
        if (act[8] === 1'b1 && !pg1) begin g_cyc.push_back(c); g_port.push_back(1); end
        pg0 = (act[9] === 1'b1);
        pg1 = (act[8] === 1'b1);
      end
    end

    dchk("reset_outputs", obs[2], IDLE_OUT);
    dchk("gnt0_latency", {obs[c_req][9], obs[c_req+1][9]}, 2'b01);
    for (int i = 3; i <= 5; i++) begin
      dchk("pass_through0", obs[c_req+i][4:1], drv[c_req+i]);
      dchk("miso1_idle", obs[c_req+i][0], 1'b0);
    end

    dchk("rel_csel_low_while_owned", {obs[c_n][9], obs[c_n][4]}, 2'b10);
    dchk("rel_gnt_drop_csel_high", {obs[c_n+1][9], obs[c_n+1][4]}, 2'b01);
    dchk("gap_busy", cnt(c_n+1, c_n+4, 7), 4);
    dchk("gap_forced_lines", cnt(c_n+1, c_n+4, 3) + cnt(c_n+1, c_n+4, 2) +
         cnt(c_n+1, c_n+4, 1) + cnt(c_n+1, c_n+4, 0), 0);
    dchk("gap_then_idle", obs[c_n+5][7], 1'b0);
    dchk("gap_regrant", {obs[c_n+5][8], obs[c_n+6][8]}, 2'b01);

    for (int i = 0; i < 4; i++) begin rr_c[i] = -1; rr_p[i] = -1; end
    k = 0;
    for (int i = 0; i < g_cyc.size(); i++) begin
      if (g_cyc[i] >= c_d && k < 4) begin
        rr_c[k] = g_cyc[i]; rr_p[k] = g_port[i]; k++;
      end
    end
    dchk("rr_first_grant_cycle", rr_c[0], c_d + 1);
    dchk("rr_second_grant_cycle", rr_c[1], c_d + 27);
    for (int i = 0; i < 4; i++) dchk("rr_order", rr_p[i], i % 2);

    dchk("hold_gnt_cycles", cnt(c_e+1, c_e+105, 8), HOLD_LIMIT);
    dchk("hold_gnt_drop", {obs[c_e+100][8], obs[c_e+101][8]}, 2'b10);
    dchk("hold_abort_pulse", obs[c_e+101][6:5], 2'b10);
    dchk("hold_abort_once", cnt(c_e, c_e+160, 6) + cnt(c_e, c_e+160, 5), 1);
    dchk("lockout_other_served", obs[c_e+106][9], 1'b1);
    dchk("lockout_no_regrant", cnt(c_e+101, c_e+156, 8), 0);
    dchk("lockout_cleared_regrant", obs[c_e+157][8], 1'b1);

    dchk("simul_last_owned_cycle", {obs[c_f+100][9], obs[c_f+101][9]}, 2'b10);
    dchk("simul_no_abort", cnt(c_f, c_f+115, 5) + cnt(c_f, c_f+115, 6), 0);
    dchk("simul_regrant_after_gap", {obs[c_f+105][9], obs[c_f+106][9]}, 2'b01);

    dchk("rst_before", {obs[c_r][8], obs[c_r][4]}, 2'b10);
    dchk("rst_after", obs[c_r+1], IDLE_OUT);
    dchk("rst_port0_first", {obs[c_r+2][9], obs[c_r+2][8]}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single SPI flash port (csel/sclk/mosi/miso) between two requesters: port 0 is the DFU flash engine, port 1 is the boot-image/multiboot header reader.
- Transaction-level arbitration: the owner keeps the bus for as long as it holds its request.
- Enforces a chip-select-high gap between owners and an optional per-owner hold limit with forced release.
- Sits between the requesters and the flash pins / USRMCLK clock block in the board top level.

Parameters:
- CS_GAP, 4, cycles of forced spi_csel=1 / spi_clk=0 after any ownership ends; must be >=1.
- HOLD_LIMIT, 0, maximum cycles one owner may hold the bus; 0 disables the limit; compared against a 24-bit counter.

Ports:
- clk_48mhz  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 bus request, level.
- gnt0  out  1  port 0 owns the bus.
- csel0, sclk0, mosi0  in  1 each  port 0 SPI drive.
- miso0  out  1  port 0 SPI return.
- req1, gnt1, csel1, sclk1, mosi1, miso1: port 1, same widths and meanings as port 0.
- abort  out  2  one-cycle pulse per port on forced release (bit0 = port 0).
- busy  out  1  high in OWN0, OWN1 and GAP.
- spi_csel  out  1  to flash; idle high.
- spi_clk  out  1  to USRMCLK; idle low.
- spi_mosi  out  1  to flash; idle low.
- spi_miso  in  1  from flash.

Behaviour:
- Reset values: state=IDLE, gnt0=gnt1=0, abort=0, busy=0, spi_csel=1, spi_clk=0, spi_mosi=0, miso0=miso1=0, last_owner=1 (port 0 wins first), lockout0=lockout1=0, hold and gap counters=0.
- States are IDLE, OWN0, OWN1 and GAP. gnt0/gnt1 and busy decode directly from the registered state.
- IDLE, exactly one eligible req: move to the matching OWNx on the next edge, so gnt goes high one cycle after req is sampled.
  - reqx is eligible only when reqx=1 and lockoutx=0.
- IDLE, both eligible: grant the port that is not last_owner (round-robin); last_owner updates on grant.
- OWNx:
  - Outputs are a combinational pass-through: spi_csel=cselx, spi_clk=sclkx, spi_mosi=mosix, misox=spi_miso.
  - The other port's miso is 0.
  - The requester must not assume ownership before it sees gntx=1.
- OWNx, reqx falls: go to GAP on the next edge, so gntx drops that edge.
  - The arbiter drives spi_csel=1 from that edge regardless of cselx.
  - A requester that drops req mid-byte corrupts only its own transaction.
- Hold counter:
  - Cleared on entry to OWNx and incremented each OWN cycle.
  - If HOLD_LIMIT!=0 and the counter reaches HOLD_LIMIT-1 while reqx=1: go to GAP, pulse abort[x] for exactly one cycle, and set lockoutx.
- lockoutx clears on the first cycle reqx=0. Until then port x is not eligible and the other port may be granted.
- GAP:
  - Outputs are forced to spi_csel=1, spi_clk=0, spi_mosi=0, and both miso outputs are 0.
  - The gap counter counts CS_GAP cycles, then the state goes to IDLE.
  - Earliest re-grant is CS_GAP+1 cycles after gnt drops.
- Requests arriving in GAP are held off. Request changes in GAP are ignored except for clearing lockout.
- Simultaneous reqx fall and hold-limit hit on the same cycle: treat it as a normal release. No abort pulse and no lockout.
- Reset asserted mid-transaction: on the next edge all outputs take their reset values (spi_csel=1, gnt=0). No gap is enforced after reset.
- Unowned port: its SPI inputs are ignored in every state.

Test Plan:
- Single requester: reset, then req0=1 at cycle 10 -> gnt0=1 at cycle 11. Toggle sclk0/mosi0/csel0 -> they appear on spi_clk/spi_mosi/spi_csel the same cycle. spi_miso=1 -> miso0=1 and miso1=0.
- Release and gap: with CS_GAP=4, drop req0 at cycle N with csel0=0 -> gnt0=0 and spi_csel=1 from N+1; busy stays high through N+4; a pending req1 sees gnt1=1 at N+6.
- Round-robin: req0 and req1 both held high, each owner releasing after 20 cycles and re-requesting -> grants alternate 0,1,0,1 with the first grant to port 0.
- Hold limit: HOLD_LIMIT=100 and req1 held high -> gnt1 falls after 100 grant cycles and abort[1] pulses once. Keeping req1 high gives no re-grant while port 0 is served. req1 low for 1 cycle then high -> granted again after the gap.
- Simultaneous release and limit: req0 falls on the same cycle the limit is hit -> abort=0, no lockout, and immediate re-request is honoured after CS_GAP.
- Reset mid-transfer: assert reset while gnt1=1 and spi_csel=0 -> next cycle spi_csel=1, spi_clk=0, gnt1=0, state IDLE. After release, req0 is granted first (last_owner=1).
